rdn_weight_seq: RTL and testbench
=================================

Name: rdn_weight_seq

Overview:
- Sequences the RDN weight-load phase. Pulls the packed weight image for all A, B and C neurons from a 16-bit-word memory port and streams each word to its target neuron as a layer/neuron/index write.
- Replaces the open memory-side connection of the RDN weight loading path.
- Keeps up to MAX_OUT reads in flight. Raises weight_valid when every neuron is loaded.

Parameters:
- NUM_A_NEURONS, 15, A-layer neuron count; each A neuron takes A_WORDS words.
- NUM_B_NEURONS, 15, B-layer neuron count; each B neuron takes NUM_A_NEURONS+1 words.
- NUM_C_NEURONS, 36, C-layer neuron count; each C neuron takes NUM_B_NEURONS+1 words.
- A_WORDS, 401, words per A neuron (bias + 400 weights).
- ADDR_W, 32, memory word-address width.
- MAX_OUT, 4, maximum outstanding read requests (1..15).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- go  in  1  start pulse; base_addr sampled on the same cycle
- base_addr  in  ADDR_W  word address of the first weight word
- mem_req_valid  out  1  read request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  ADDR_W  read word address
- mem_rsp_valid  in  1  read data valid; responses return in order
- mem_rsp_data  in  16  read data
- wr_en  out  1  one-cycle write strobe to neuron weight storage
- wr_layer  out  2  0=A, 1=B, 2=C
- wr_neuron  out  6  neuron index within the layer
- wr_idx  out  9  0 = bias, k = weight k-1
- wr_data  out  16  word to write
- busy  out  1  load in progress
- weight_valid  out  1  all weights loaded
- err  out  1  sticky: response received with zero outstanding

Behaviour:
- Reset: all outputs 0, state IDLE, all counters 0.
- Image layout: contiguous words, in this order:
  - A0..A(n-1), A_WORDS each;
  - then B neurons, NUM_A_NEURONS+1 each;
  - then C neurons, NUM_B_NEURONS+1 each.
  - TOTAL = 15*401+15*16+36*16 = 6831 at defaults.
  - Within a neuron: word 0 is the bias, then weights in order.
- States:
  - IDLE: go -> RUN; latch base_addr; clear issue/response counters, err and weight_valid.
  - RUN: busy=1; issue and retire requests. After the TOTAL-th response is written -> DONE. go is ignored in RUN.
  - DONE: weight_valid=1, busy=0. go -> RUN (weight_valid drops the next cycle).
- Issue:
  - mem_req_valid=1 when issued<TOTAL and outstanding<MAX_OUT; both conditions use registered counts.
  - mem_req_addr = base + issued.
  - Once asserted, valid and addr hold stable until mem_req_ready.
  - Handshake on valid&ready: issued+1, outstanding+1.
- Response:
  - On mem_rsp_valid with outstanding>0: outstanding-1.
  - Register wr_data, and wr_layer/neuron/idx from the response cursor; wr_en=1 the next cycle (latency 1). Advance the cursor.
  - Accept and response in the same cycle: outstanding unchanged.
- Cursor: wr_idx wraps at the per-layer word count and increments wr_neuron. wr_neuron wraps at the layer count and increments wr_layer. No cursor wrap past C.
- err: mem_rsp_valid with outstanding==0 (in any state) sets err and is otherwise ignored: no wr_en, no cursor move. err clears only on go or rst.
- Completion: weight_valid rises the cycle after the final wr_en; the final wr_en is C35, idx 15 at defaults.
- rst mid-RUN: immediate return to IDLE. Late memory responses then hit the err rule.
- mem_req_ready while mem_req_valid=0 has no effect.

Test Plan:
- Zero-wait memory (ready=1, rsp 1 cycle after accept, data = low 16 bits of address), base 0x100, go:
  - 6831 wr_en pulses, in order;
  - first write: layer 0, neuron 0, idx 0, data 0x0100;
  - word 6015: layer 1, neuron 0, idx 0;
  - last write: layer 2, neuron 35, idx 15;
  - weight_valid=1 exactly one cycle after the last wr_en.
- Memory holding responses (rsp_valid=0), ready=1 -> exactly MAX_OUT=4 requests (addr base..base+3) accepted, then mem_req_valid=0 until a response arrives.
- ready held 0 for 5 cycles during RUN -> mem_req_valid and mem_req_addr stable across all 5 cycles; no duplicate or skipped address.
- rst asserted after 100 responses, then a stray rsp_valid -> busy=0, weight_valid=0, err=1, no wr_en; a following go clears err and restarts at base_addr.
- go during RUN -> ignored; issue sequence unchanged. go in DONE -> weight_valid=0 next cycle and a full reload runs.

Source files
------------

// File: rtl/rdn_weight_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : rdn_weight_seq_if
// Brief    : Memory read port and neuron weight-write bus of the RDN weight loader.
// Revision : 1.0
// ============================================================================
interface rdn_weight_seq_if #(
  parameter int ADDR_W = 32
);
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_rsp_valid;
  logic [15:0]       mem_rsp_data;

  logic              wr_en;
  logic [1:0]        wr_layer;
  logic [5:0]        wr_neuron;
  logic [8:0]        wr_idx;
  logic [15:0]       wr_data;

  modport master (
    output mem_req_valid, mem_req_addr,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
    output wr_en, wr_layer, wr_neuron, wr_idx, wr_data
  );

  modport slave (
    input  mem_req_valid, mem_req_addr,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data,
    input  wr_en, wr_layer, wr_neuron, wr_idx, wr_data
  );
endinterface
`default_nettype wire

// File: rtl/rdn_weight_seq.sv
`default_nettype none
// ============================================================================
// Module   : rdn_weight_seq
// Brief    : Streams the packed A/B/C weight image from memory into neuron storage.
// Revision : 1.0
// ============================================================================
module rdn_weight_seq #(
  parameter int NUM_A_NEURONS = 15,
  parameter int NUM_B_NEURONS = 15,
  parameter int NUM_C_NEURONS = 36,
  parameter int A_WORDS       = 401,
  parameter int ADDR_W        = 32,
  parameter int MAX_OUT       = 4
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              go,
  input  wire logic [ADDR_W-1:0] base_addr,
  rdn_weight_seq_if.master       bus,
  output logic                   busy,
  output logic                   weight_valid,
  output logic                   err
);
  localparam int TOTAL = NUM_A_NEURONS * A_WORDS
                       + NUM_B_NEURONS * (NUM_A_NEURONS + 1)
                       + NUM_C_NEURONS * (NUM_B_NEURONS + 1);
  localparam int CNT_W = $clog2(TOTAL + 1);

  localparam logic [CNT_W-1:0] C_TOTAL   = CNT_W'(TOTAL);
  localparam logic [CNT_W-1:0] C_LAST    = CNT_W'(TOTAL - 1);
  localparam logic [3:0]       C_MAX_OUT = 4'(MAX_OUT);
  localparam logic [8:0]       C_A_WORDS = 9'(A_WORDS);
  localparam logic [8:0]       C_B_WORDS = 9'(NUM_A_NEURONS + 1);
  localparam logic [8:0]       C_C_WORDS = 9'(NUM_B_NEURONS + 1);
  localparam logic [5:0]       C_A_CNT   = 6'(NUM_A_NEURONS);
  localparam logic [5:0]       C_B_CNT   = 6'(NUM_B_NEURONS);
  localparam logic [5:0]       C_C_CNT   = 6'(NUM_C_NEURONS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_base;
  logic [CNT_W-1:0]  r_issued;
  logic [CNT_W-1:0]  r_retired;
  logic [3:0]        r_outst;
  logic [1:0]        r_cur_layer;
  logic [5:0]        r_cur_neuron;
  logic [8:0]        r_cur_idx;
  logic              r_wr_en;
  logic              r_wr_last;
  logic [1:0]        r_wr_layer;
  logic [5:0]        r_wr_neuron;
  logic [8:0]        r_wr_idx;
  logic [15:0]       r_wr_data;
  logic              r_err;

  logic              w_start;
  logic              w_req_valid;
  logic              w_req_fire;
  logic              w_rsp_ok;
  logic              w_rsp_err;
  logic [8:0]        w_words;
  logic [5:0]        w_cnt;
  logic [1:0]        w_cur_layer_nxt;
  logic [5:0]        w_cur_neuron_nxt;
  logic [8:0]        w_cur_idx_nxt;

  // Request valid/addr depend only on registered counts, so they hold until accepted.
  assign w_req_valid = (r_state == S_RUN) && (r_issued < C_TOTAL) && (r_outst < C_MAX_OUT);
  assign w_req_fire  = w_req_valid && bus.mem_req_ready;
  assign w_rsp_ok    = bus.mem_rsp_valid && (r_outst != 4'd0);
  assign w_rsp_err   = bus.mem_rsp_valid && (r_outst == 4'd0);

  assign bus.mem_req_valid = w_req_valid;
  assign bus.mem_req_addr  = r_base + ADDR_W'(r_issued);
  assign bus.wr_en         = r_wr_en;
  assign bus.wr_layer      = r_wr_layer;
  assign bus.wr_neuron     = r_wr_neuron;
  assign bus.wr_idx        = r_wr_idx;
  assign bus.wr_data       = r_wr_data;
  assign err               = r_err;

  always_comb begin
    w_state_nxt  = r_state;
    w_start      = 1'b0;
    busy         = 1'b0;
    weight_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (go) begin
          w_start     = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (r_wr_en && r_wr_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        weight_valid = 1'b1;
        if (go) begin
          w_start     = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_words = C_C_WORDS;
    w_cnt   = C_C_CNT;
    case (r_cur_layer)
      2'd0: begin w_words = C_A_WORDS; w_cnt = C_A_CNT; end
      2'd1: begin w_words = C_B_WORDS; w_cnt = C_B_CNT; end
      default: ;
    endcase
    w_cur_idx_nxt    = r_cur_idx + 9'd1;
    w_cur_neuron_nxt = r_cur_neuron;
    w_cur_layer_nxt  = r_cur_layer;
    if (r_cur_idx == w_words - 9'd1) begin
      w_cur_idx_nxt = 9'd0;
      if (r_cur_neuron == w_cnt - 6'd1) begin
        w_cur_neuron_nxt = 6'd0;
        if (r_cur_layer != 2'd2) w_cur_layer_nxt = r_cur_layer + 2'd1;
      end else begin
        w_cur_neuron_nxt = r_cur_neuron + 6'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_base       <= '0;
      r_issued     <= '0;
      r_retired    <= '0;
      r_outst      <= 4'd0;
      r_cur_layer  <= 2'd0;
      r_cur_neuron <= 6'd0;
      r_cur_idx    <= 9'd0;
      r_wr_en      <= 1'b0;
      r_wr_last    <= 1'b0;
      r_wr_layer   <= 2'd0;
      r_wr_neuron  <= 6'd0;
      r_wr_idx     <= 9'd0;
      r_wr_data    <= 16'd0;
      r_err        <= 1'b0;
    end else begin
      r_wr_en   <= 1'b0;
      r_wr_last <= 1'b0;
      if (w_start) begin
        r_base       <= base_addr;
        r_issued     <= '0;
        r_retired    <= '0;
        r_outst      <= 4'd0;
        r_cur_layer  <= 2'd0;
        r_cur_neuron <= 6'd0;
        r_cur_idx    <= 9'd0;
        r_err        <= 1'b0;
      end else begin
        if (w_req_fire) r_issued <= r_issued + 1'b1;
        case ({w_req_fire, w_rsp_ok})
          2'b10:   r_outst <= r_outst + 4'd1;
          2'b01:   r_outst <= r_outst - 4'd1;
          default: ;
        endcase
        if (w_rsp_ok) begin
          r_wr_en      <= 1'b1;
          r_wr_last    <= (r_retired == C_LAST);
          r_wr_layer   <= r_cur_layer;
          r_wr_neuron  <= r_cur_neuron;
          r_wr_idx     <= r_cur_idx;
          r_wr_data    <= bus.mem_rsp_data;
          r_retired    <= r_retired + 1'b1;
          r_cur_layer  <= w_cur_layer_nxt;
          r_cur_neuron <= w_cur_neuron_nxt;
          r_cur_idx    <= w_cur_idx_nxt;
        end
      end
      // A stray response in the same cycle as go still leaves err set.
      if (w_rsp_err) r_err <= 1'b1;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_rdn_weight_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_rdn_weight_seq
// Brief    : Directed self-checking bench for the RDN weight-load sequencer.
// Revision : 1.0
// ============================================================================
module tb_rdn_weight_seq;
  localparam int TOTAL = 6831;

  typedef struct {
    logic [1:0]  layer;
    logic [5:0]  neuron;
    logic [8:0]  idx;
    logic [15:0] data;
    int          cyc;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        go;
  logic [31:0] base_addr;
  logic        busy;
  logic        weight_valid;
  logic        err;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          wv_rise_cyc = -1;
  logic        prev_wv = 1'b0;
  logic        rsp_en = 1'b0;
  int          stray_cnt = 0;
  int          stray_done = 0;
  logic        m_acc;
  logic [31:0] m_addr;
  logic [31:0] m_pop;
  logic [31:0] q[$];
  logic [31:0] acc_log[$];
  wr_t         wr_log[$];

  rdn_weight_seq_if #(.ADDR_W(32)) bus ();

  rdn_weight_seq #(
    .NUM_A_NEURONS(15), .NUM_B_NEURONS(15), .NUM_C_NEURONS(36),
    .A_WORDS(401), .ADDR_W(32), .MAX_OUT(4)
  ) dut (
    .clk(clk), .rst(rst), .go(go), .base_addr(base_addr), .bus(bus),
    .busy(busy), .weight_valid(weight_valid), .err(err)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // Memory: returns data = low address bits one cycle after each accept, in order.
  initial begin
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = 16'd0;
    forever begin
      @(negedge clk);
      m_acc  = bus.mem_req_valid && bus.mem_req_ready && !rst;
      m_addr = bus.mem_req_addr;
      @(posedge clk);
      #1;
      if (m_acc) begin
        q.push_back(m_addr);
        acc_log.push_back(m_addr);
      end
      bus.mem_rsp_valid = 1'b0;
      if (stray_cnt != stray_done) begin
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = 16'hDEAD;
        stray_done        = stray_done + 1;
      end else if (rsp_en && q.size() > 0) begin
        m_pop             = q.pop_front();
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = m_pop[15:0];
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (bus.wr_en) wr_log.push_back('{bus.wr_layer, bus.wr_neuron, bus.wr_idx, bus.wr_data, cyc});
    if (weight_valid && !prev_wv) wv_rise_cyc = cyc;
    prev_wv = weight_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_go(input logic [31:0] base);
    base_addr = base;
    go        = 1'b1;
    tick();
    go        = 1'b0;
  endtask

  task automatic wait_wv(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (weight_valid === 1'b1) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; go = 1'b0; base_addr = 32'd0;
    bus.mem_req_ready = 1'b1; rsp_en = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    vectors++;
    if ({bus.mem_req_valid, bus.wr_en, busy, weight_valid, err, bus.wr_layer, bus.wr_neuron,
         bus.wr_idx, bus.wr_data} !== 38'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got valid=%b wr_en=%b busy=%b wv=%b err=%b expected all 0",
               bus.mem_req_valid, bus.wr_en, busy, weight_valid, err);
    end
    tick();
    rst = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    vectors++;
    if ({bus.mem_req_valid, bus.wr_en, busy, weight_valid, err} !== 5'd0) begin
      miscompares++;
      $display("FAIL idle_quiet: got valid=%b wr_en=%b busy=%b wv=%b err=%b expected all 0",
               bus.mem_req_valid, bus.wr_en, busy, weight_valid, err);
    end
  endtask

  task automatic test_zero_wait();
    int s_wr, s_acc, n, bad, k, first_bad;
    bit ok;
    wr_t e;
    s_wr = wr_log.size(); s_acc = acc_log.size();
    pulse_go(32'h100);
    wait_wv(20000, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL zw_timeout: got weight_valid=0 expected 1 within 20000 cycles");
    end
    n = wr_log.size() - s_wr;
    vectors++;
    if (n != TOTAL) begin
      miscompares++;
      $display("FAIL zw_write_count: got %0d expected %0d", n, TOTAL);
    end
    vectors++;
    if (n < 1 || {wr_log[s_wr].layer, wr_log[s_wr].neuron, wr_log[s_wr].idx, wr_log[s_wr].data}
                 !== {2'd0, 6'd0, 9'd0, 16'h0100}) begin
      miscompares++;
      $display("FAIL zw_first_write: got n=%0d expected layer 0 neuron 0 idx 0 data 0100", n);
    end
    vectors++;
    if (n <= 6015 || {wr_log[s_wr+6015].layer, wr_log[s_wr+6015].neuron, wr_log[s_wr+6015].idx,
                      wr_log[s_wr+6015].data} !== {2'd1, 6'd0, 9'd0, 16'h187F}) begin
      miscompares++;
      $display("FAIL zw_word6015: got n=%0d expected layer 1 neuron 0 idx 0 data 187f", n);
    end
    vectors++;
    if (n < TOTAL || {wr_log[s_wr+TOTAL-1].layer, wr_log[s_wr+TOTAL-1].neuron,
                      wr_log[s_wr+TOTAL-1].idx, wr_log[s_wr+TOTAL-1].data}
                     !== {2'd2, 6'd35, 9'd15, 16'h1BAE}) begin
      miscompares++;
      $display("FAIL zw_last_write: got n=%0d expected layer 2 neuron 35 idx 15 data 1bae", n);
    end
    // Walk the expected image layout and compare every write in order.
    bad = 0; k = 0; first_bad = -1;
    for (int l = 0; l < 3; l++) begin
      for (int nn = 0; nn < ((l == 0) ? 15 : (l == 1) ? 15 : 36); nn++) begin
        for (int w = 0; w < ((l == 0) ? 401 : 16); w++) begin
          if (k < n) begin
            e = wr_log[s_wr+k];
            if (e.layer !== 2'(l) || e.neuron !== 6'(nn) || e.idx !== 9'(w) ||
                e.data !== 16'(32'h100 + k)) begin
              bad++;
              if (first_bad < 0) first_bad = k;
            end
          end
          k++;
        end
      end
    end
    vectors++;
    if (bad != 0 || n != TOTAL) begin
      miscompares++;
      $display("FAIL zw_write_order: got %0d bad writes (first at %0d) of %0d expected 0 of %0d",
               bad, first_bad, n, TOTAL);
    end
    vectors++;
    if (n < 1 || wv_rise_cyc - wr_log[s_wr+n-1].cyc != 1) begin
      miscompares++;
      $display("FAIL zw_wv_latency: got %0d cycles after last wr_en expected 1",
               (n < 1) ? -1 : wv_rise_cyc - wr_log[s_wr+n-1].cyc);
    end
    vectors++;
    if ({busy, err, weight_valid} !== 3'b001) begin
      miscompares++;
      $display("FAIL zw_done_status: got busy=%b err=%b wv=%b expected 0 0 1", busy, err, weight_valid);
    end
    bad = 0;
    for (int i = s_acc; i < acc_log.size(); i++)
      if (acc_log[i] !== 32'h100 + 32'(i - s_acc)) bad++;
    vectors++;
    if (bad != 0 || acc_log.size() - s_acc != TOTAL) begin
      miscompares++;
      $display("FAIL zw_req_addrs: got %0d requests with %0d out of sequence expected %0d in order",
               acc_log.size() - s_acc, bad, TOTAL);
    end
  endtask

  task automatic test_hold_and_stall();
    int s_wr, s_acc, bad;
    bit ok;
    logic [31:0] a0;
    s_wr = wr_log.size(); s_acc = acc_log.size();
    rsp_en = 1'b0;
    pulse_go(32'h2000);
    @(negedge clk);
    vectors++;
    if ({weight_valid, busy} !== 2'b01) begin
      miscompares++;
      $display("FAIL go_in_done: got wv=%b busy=%b expected wv=0 busy=1", weight_valid, busy);
    end
    repeat (20) tick();
    @(negedge clk);
    vectors++;
    if (acc_log.size() - s_acc != 4) begin
      miscompares++;
      $display("FAIL hold_req_count: got %0d expected 4", acc_log.size() - s_acc);
    end
    vectors++;
    if (acc_log.size() - s_acc < 4 || acc_log[s_acc] !== 32'h2000 || acc_log[s_acc+1] !== 32'h2001 ||
        acc_log[s_acc+2] !== 32'h2002 || acc_log[s_acc+3] !== 32'h2003) begin
      miscompares++;
      $display("FAIL hold_req_addrs: got first addr %h expected 2000..2003",
               (acc_log.size() > s_acc) ? acc_log[s_acc] : 32'hFFFFFFFF);
    end
    vectors++;
    if (bus.mem_req_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL hold_valid_low: got %b expected 0", bus.mem_req_valid);
    end
    rsp_en = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      if (bus.mem_req_valid === 1'b1) ok = 1'b1;
    end
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL hold_resume: got mem_req_valid=0 expected 1 within 10 cycles of responses");
    end
    repeat (50) tick();
    bus.mem_req_ready = 1'b0;
    @(negedge clk);
    a0 = bus.mem_req_addr;
    vectors++;
    if (bus.mem_req_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_valid: got %b expected 1", bus.mem_req_valid);
    end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge clk);
      if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== a0) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL stall_stable: got %0d unstable cycles (addr now %h) expected 0 (addr %h)",
               bad, bus.mem_req_addr, a0);
    end
    tick();
    bus.mem_req_ready = 1'b1;
    repeat (20) tick();
    pulse_go(32'h7777);
    @(negedge clk);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL go_in_run_busy: got %b expected 1", busy);
    end
    wait_wv(20000, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL stall_timeout: got weight_valid=0 expected 1 within 20000 cycles");
    end
    bad = 0;
    for (int i = s_acc; i < acc_log.size(); i++)
      if (acc_log[i] !== 32'h2000 + 32'(i - s_acc)) bad++;
    vectors++;
    if (bad != 0 || acc_log.size() - s_acc != TOTAL) begin
      miscompares++;
      $display("FAIL stall_req_addrs: got %0d requests with %0d out of sequence expected %0d in order",
               acc_log.size() - s_acc, bad, TOTAL);
    end
    vectors++;
    if (wr_log.size() - s_wr != TOTAL) begin
      miscompares++;
      $display("FAIL stall_write_count: got %0d expected %0d", wr_log.size() - s_wr, TOTAL);
    end
  endtask

  task automatic test_rst_midrun();
    int s_wr, s_acc, n_wr;
    bit ok;
    s_wr = wr_log.size();
    pulse_go(32'h4000);
    ok = 1'b0;
    for (int i = 0; i < 1000 && !ok; i++) begin
      @(negedge clk);
      if (wr_log.size() - s_wr >= 100) ok = 1'b1;
    end
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL rst_reach_100: got %0d writes expected 100 within 1000 cycles", wr_log.size() - s_wr);
    end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_wr = wr_log.size();
    vectors++;
    if ({busy, weight_valid, bus.mem_req_valid, bus.wr_en} !== 4'd0) begin
      miscompares++;
      $display("FAIL rst_midrun_idle: got busy=%b wv=%b valid=%b wr_en=%b expected all 0",
               busy, weight_valid, bus.mem_req_valid, bus.wr_en);
    end
    repeat (5) tick();
    stray_cnt = stray_cnt + 1;
    repeat (3) tick();
    @(negedge clk);
    vectors++;
    if ({err, busy, weight_valid} !== 3'b100) begin
      miscompares++;
      $display("FAIL rst_stray_err: got err=%b busy=%b wv=%b expected 1 0 0", err, busy, weight_valid);
    end
    vectors++;
    if (wr_log.size() != n_wr) begin
      miscompares++;
      $display("FAIL rst_no_write: got %0d writes after reset expected 0", wr_log.size() - n_wr);
    end
    s_acc = acc_log.size();
    pulse_go(32'h3000);
    @(negedge clk);
    vectors++;
    if ({err, busy} !== 2'b01) begin
      miscompares++;
      $display("FAIL go_clears_err: got err=%b busy=%b expected 0 1", err, busy);
    end
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      if (acc_log.size() > s_acc) ok = 1'b1;
    end
    vectors++;
    if (!ok || acc_log[s_acc] !== 32'h3000) begin
      miscompares++;
      $display("FAIL restart_addr: got %h expected 00003000",
               ok ? acc_log[s_acc] : 32'hFFFFFFFF);
    end
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_hold_and_stall();
    test_rst_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
